decoder_seq: RTL and testbench

//   Registered, parametrised N-to-2^N one-hot decoder; sequential successor to the fixed
//   2-to-4 combinational LUT decoder. Two modes: DIRECT (load an index, hold its one-hot

---
 rtl/decoder_seq.sv | 182 ++++++++++++++++++
 tb/tb_decoder_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_seq
//  Description : Registered, parametrised N-to-2^N one-hot decoder with two
//                modes. DIRECT holds the one-hot code of a loaded index; SCAN
//                steps through indices 0..LAST, holding each for DWELL cycles
//                (0 treated as 1), and pulses WRAP when the index returns to 0.
//                Intended for row/column strobes, chip-selects and
//                time-multiplexed enables.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N           index width; O is 2^N bits wide
//    DWELL_W     width of DWELL and of the internal dwell counter
//    ACTIVE_LOW  1: every bit of O inverted (inactive = all ones)
//  Ports
//    CLK         in   clock, rising edge
//    ASYNCRESET  in   asynchronous active-high reset
//    CLR         in   synchronous clear to IDLE
//    MODE        in   0 = DIRECT, 1 = SCAN
//    LOAD        in   DIRECT: capture I this cycle
//    I           in   DIRECT index
//    EN          in   SCAN: run (1) / pause (0)
//    DWELL       in   cycles each index is held in SCAN (0 behaves as 1)
//    LAST        in   highest SCAN index; wraps to 0 after it
//    O           out  one-hot of IDX when active, else inactive (registered)
//    IDX         out  current index (registered)
//    WRAP        out  1-cycle pulse on the first cycle IDX shows 0 after a wrap
// ============================================================================
module decoder_seq #(
    parameter int N          = 2,
    parameter int DWELL_W    = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    input  logic                 CLR,
    input  logic                 MODE,
    input  logic                 LOAD,
    input  logic [N-1:0]         I,
    input  logic                 EN,
    input  logic [DWELL_W-1:0]   DWELL,
    input  logic [N-1:0]         LAST,
    output logic [(1<<N)-1:0]    O,
    output logic [N-1:0]         IDX,
    output logic                 WRAP
);

    localparam int c_OW = 1 << N;

    // XOR mask applied to the one-hot code: all ones for active-low outputs.
    localparam logic [c_OW-1:0] c_INACTIVE = (ACTIVE_LOW != 0) ? {c_OW{1'b1}}
                                                                : {c_OW{1'b0}};
    localparam logic [c_OW-1:0] c_ONE      = {{(c_OW-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DIRECT = 2'd1;
    localparam logic [1:0] c_ST_SCAN   = 2'd2;

    logic [1:0]         r_state;
    logic [N-1:0]       r_idx;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_wrap;
    logic [c_OW-1:0]    r_o;

    logic [1:0]         w_state_nx;
    logic [N-1:0]       w_idx_nx;
    logic [DWELL_W-1:0] w_cnt_nx;
    logic               w_wrap_nx;
    logic [c_OW-1:0]    w_o_nx;

    logic [DWELL_W-1:0] w_dlast;
    logic               w_term;
    logic               w_at_last;

    // Terminal count of the current dwell. DWELL=0 behaves as DWELL=1, so
    // the terminal value is 0 in both cases. Using >= means a DWELL lowered
    // below the running count ends the dwell at the next compare instead of
    // running the counter all the way round.
    assign w_dlast   = (DWELL == '0) ? '0 : (DWELL - 1'b1);
    assign w_term    = (r_cnt >= w_dlast);
    // >= rather than == so a LAST lowered beneath IDX mid-scan wraps at the
    // next terminal rather than stepping through out-of-range indices.
    assign w_at_last = (r_idx >= LAST);

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_wrap_nx  = 1'b0;

        if (CLR) begin
            w_state_nx = c_ST_IDLE;
            w_idx_nx   = '0;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!MODE && LOAD) begin
                        w_state_nx = c_ST_DIRECT;
                        w_idx_nx   = I;
                    end else if (MODE && EN) begin
                        w_state_nx = c_ST_SCAN;
                        w_idx_nx   = '0;
                        w_cnt_nx   = '0;
                    end
                end

                c_ST_DIRECT: begin
                    if (!MODE) begin
                        if (LOAD) begin
                            w_idx_nx = I;
                        end
                    end else if (EN) begin
                        w_state_nx = c_ST_SCAN;
                        w_idx_nx   = '0;
                        w_cnt_nx   = '0;
                    end else begin
                        w_state_nx = c_ST_IDLE;
                    end
                end

                c_ST_SCAN: begin
                    if (!MODE) begin
                        // IDX keeps its last value; only O goes inactive.
                        w_state_nx = c_ST_IDLE;
                    end else if (EN) begin
                        if (!w_term) begin
                            w_cnt_nx = r_cnt + 1'b1;
                        end else begin
                            w_cnt_nx = '0;
                            if (w_at_last) begin
                                w_idx_nx  = '0;
                                w_wrap_nx = 1'b1;
                            end else begin
                                w_idx_nx  = r_idx + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    w_state_nx = c_ST_IDLE;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // O is built from the next state/index so it changes on the same edge
    // as IDX and never lags it by a cycle.
    always_comb begin
        w_o_nx = '0;
        if (w_state_nx != c_ST_IDLE) begin
            w_o_nx = c_ONE << w_idx_nx;
        end
        w_o_nx = w_o_nx ^ c_INACTIVE;
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
            r_o     <= c_INACTIVE;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
            r_wrap  <= w_wrap_nx;
            r_o     <= w_o_nx;
        end
    end

    assign O    = r_o;
    assign IDX  = r_idx;
    assign WRAP = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_seq
//  Description : Self-checking bench for decoder_seq. A table of directed
//                vectors, hand-written multi-cycle sequences and a randomised
//                run compared with a behavioural model. A second instance
//                (N=3, ACTIVE_LOW=1) covers the inverted-output variant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_seq;

    logic       clk;
    logic       arst;

    // main instance (N=2, active high)
    logic       clr, mode, load, en;
    logic [1:0] idx_in, last;
    logic [7:0] dwell;
    logic [3:0] o;
    logic [1:0] idx;
    logic       wrap;

    // second instance (N=3, active low)
    logic       al_clr, al_mode, al_load, al_en;
    logic [2:0] al_i, al_last;
    logic [7:0] al_dwell;
    logic [7:0] al_o;
    logic [2:0] al_idx;
    logic       al_wrap;

    int total = 0;
    int bad   = 0;

    decoder_seq #(.N(2), .DWELL_W(8), .ACTIVE_LOW(0)) dut (
        .CLK(clk), .ASYNCRESET(arst), .CLR(clr), .MODE(mode), .LOAD(load),
        .I(idx_in), .EN(en), .DWELL(dwell), .LAST(last),
        .O(o), .IDX(idx), .WRAP(wrap)
    );

    decoder_seq #(.N(3), .DWELL_W(8), .ACTIVE_LOW(1)) dut_al (
        .CLK(clk), .ASYNCRESET(arst), .CLR(al_clr), .MODE(al_mode), .LOAD(al_load),
        .I(al_i), .EN(al_en), .DWELL(al_dwell), .LAST(al_last),
        .O(al_o), .IDX(al_idx), .WRAP(al_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic c, input logic m, input logic l, input logic [1:0] iv,
                          input logic e, input logic [7:0] d, input logic [1:0] la);
        clr = c; mode = m; load = l; idx_in = iv; en = e; dwell = d; last = la;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       clr, mode, load;
        logic [1:0] i;
        logic       en;
        logic [7:0] dwell;
        logic [1:0] last;
        logic [3:0] o;
        logic [1:0] idx;
        logic       wrap;
    } vec_t;

    vec_t vt[26];

    function automatic vec_t v(input logic c, input logic m, input logic l, input logic [1:0] iv,
                               input logic e, input logic [7:0] d, input logic [1:0] la,
                               input logic [3:0] eo, input logic [1:0] ei, input logic ew);
        vec_t r;
        r.clr = c; r.mode = m; r.load = l; r.i = iv; r.en = e; r.dwell = d; r.last = la;
        r.o = eo; r.idx = ei; r.wrap = ew;
        return r;
    endfunction

    // ---------------- behavioural reference model ----------------
    // Tracks how many cycles the current index has already been shown
    // ("age"), and moves on once it has been shown max(DWELL,1) times.
    int m_mode;   // 0 idle, 1 direct, 2 scan
    int m_idx;
    int m_age;
    int m_wrap;

    task automatic model_step();
        int d;
        m_wrap = 0;
        if (clr) begin
            m_mode = 0; m_idx = 0; m_age = 0;
        end else if (m_mode == 2) begin
            if (!mode) begin
                m_mode = 0;
            end else if (en) begin
                d = (dwell == 0) ? 1 : int'(dwell);
                if (m_age < d) begin
                    m_age++;
                end else begin
                    m_age = 1;
                    if (m_idx >= int'(last)) begin
                        m_idx = 0; m_wrap = 1;
                    end else begin
                        m_idx++;
                    end
                end
            end
        end else begin
            if (!mode && load) begin
                m_mode = 1; m_idx = int'(idx_in);
            end else if (mode && en) begin
                m_mode = 2; m_idx = 0; m_age = 1;
            end else if (mode && m_mode == 1) begin
                m_mode = 0;
            end
        end
    endtask

    function automatic logic [3:0] model_o();
        return (m_mode != 0) ? 4'(1 << m_idx) : 4'd0;
    endfunction

    initial begin
        arst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        al_clr = 0; al_mode = 0; al_load = 0; al_i = 0; al_en = 0; al_dwell = 0; al_last = 0;
        m_mode = 0; m_idx = 0; m_age = 0; m_wrap = 0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_o", 32'(o), 32'h0);
        check("reset_idx", 32'(idx), 32'h0);
        check("reset_wrap", 32'(wrap), 32'h0);
        check("al_reset_o", 32'(al_o), 32'hFF);
        arst = 1'b0;
        #1;

        // direct loads, clear, scan DWELL=2, scan DWELL=0 with pause, LAST=0
        vt[0]  = v(0,0,1,2,0,0,0, 4'b0100,2,0);
        vt[1]  = v(0,0,1,3,0,0,0, 4'b1000,3,0);
        vt[2]  = v(0,0,0,0,0,0,0, 4'b1000,3,0);
        vt[3]  = v(1,0,0,0,0,0,0, 4'b0000,0,0);
        vt[4]  = v(0,1,0,0,1,2,3, 4'b0001,0,0);
        vt[5]  = v(0,1,0,0,1,2,3, 4'b0001,0,0);
        vt[6]  = v(0,1,0,0,1,2,3, 4'b0010,1,0);
        vt[7]  = v(0,1,0,0,1,2,3, 4'b0010,1,0);
        vt[8]  = v(0,1,0,0,1,2,3, 4'b0100,2,0);
        vt[9]  = v(0,1,0,0,1,2,3, 4'b0100,2,0);
        vt[10] = v(0,1,0,0,1,2,3, 4'b1000,3,0);
        vt[11] = v(0,1,0,0,1,2,3, 4'b1000,3,0);
        vt[12] = v(0,1,0,0,1,2,3, 4'b0001,0,1);
        vt[13] = v(0,1,0,0,1,2,3, 4'b0001,0,0);
        vt[14] = v(0,0,0,0,1,2,3, 4'b0000,0,0);
        vt[15] = v(0,1,0,0,1,0,1, 4'b0001,0,0);
        vt[16] = v(0,1,0,0,1,0,1, 4'b0010,1,0);
        vt[17] = v(0,1,0,0,1,0,1, 4'b0001,0,1);
        vt[18] = v(0,1,0,0,1,0,1, 4'b0010,1,0);
        vt[19] = v(0,1,0,0,0,0,1, 4'b0010,1,0);
        vt[20] = v(0,1,0,0,0,0,1, 4'b0010,1,0);
        vt[21] = v(0,1,0,0,0,0,1, 4'b0010,1,0);
        vt[22] = v(0,1,0,0,1,0,1, 4'b0001,0,1);
        vt[23] = v(0,1,0,0,1,0,1, 4'b0010,1,0);
        vt[24] = v(0,1,0,0,1,0,0, 4'b0001,0,1);
        vt[25] = v(0,1,0,0,1,0,0, 4'b0001,0,1);

        for (int k = 0; k < 26; k++) begin
            set_in(vt[k].clr, vt[k].mode, vt[k].load, vt[k].i, vt[k].en, vt[k].dwell, vt[k].last);
            tick();
            check($sformatf("vec%0d_o", k), 32'(o), 32'(vt[k].o));
            check($sformatf("vec%0d_idx", k), 32'(idx), 32'(vt[k].idx));
            check($sformatf("vec%0d_wrap", k), 32'(wrap), 32'(vt[k].wrap));
        end

        // async reset between edges mid-scan
        set_in(0, 1, 0, 0, 1, 0, 1);
        tick();
        check("pre_arst_idx", 32'(idx), 32'h1);
        @(negedge clk);
        arst = 1'b1;
        #1;
        check("arst_o", 32'(o), 32'h0);
        check("arst_idx", 32'(idx), 32'h0);
        check("arst_wrap", 32'(wrap), 32'h0);
        check("al_arst_o", 32'(al_o), 32'hFF);
        @(negedge clk);
        arst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1;

        // lower LAST beneath IDX mid-scan, then leave SCAN
        set_in(0, 1, 0, 0, 1, 1, 3);
        for (int k = 0; k < 4; k++) tick();
        check("scan_at3_idx", 32'(idx), 32'h3);
        check("scan_at3_o", 32'(o), 32'h8);
        last = 2'd1;
        tick();
        check("lastdrop_idx", 32'(idx), 32'h0);
        check("lastdrop_wrap", 32'(wrap), 32'h1);
        check("lastdrop_o", 32'(o), 32'h1);
        mode = 1'b0;
        tick();
        check("exit_scan_o", 32'(o), 32'h0);
        check("exit_scan_wrap", 32'(wrap), 32'h0);

        // leaving SCAN keeps the last index
        set_in(0, 1, 0, 0, 1, 1, 3);
        tick(); tick(); tick();
        mode = 1'b0;
        tick();
        check("hold_idx_after_scan", 32'(idx), 32'h2);
        check("hold_o_after_scan", 32'(o), 32'h0);

        // DIRECT -> IDLE on MODE=1 & EN=0; LOAD ignored while MODE=1
        set_in(0, 0, 1, 1, 0, 0, 0);
        tick();
        check("direct_load1_o", 32'(o), 32'h2);
        set_in(0, 1, 1, 3, 0, 0, 0);
        tick();
        check("direct_to_idle_o", 32'(o), 32'h0);
        check("direct_to_idle_idx", 32'(idx), 32'h1);
        tick();
        check("idle_load_ignored_o", 32'(o), 32'h0);
        check("idle_load_ignored_idx", 32'(idx), 32'h1);

        // active-low instance: load 5, then clear
        al_load = 1'b1; al_i = 3'd5;
        tick();
        al_load = 1'b0;
        check("al_load5_o", 32'(al_o), 32'hDF);
        check("al_load5_idx", 32'(al_idx), 32'h5);
        check("al_wrap_direct", 32'(al_wrap), 32'h0);
        al_clr = 1'b1;
        tick();
        al_clr = 1'b0;
        check("al_clr_o", 32'(al_o), 32'hFF);
        check("al_clr_idx", 32'(al_idx), 32'h0);

        // randomised run against the model
        set_in(1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                clr = ($urandom_range(199) == 0);
                if ($urandom_range(24) == 0) mode = ~mode;
                load   = ($urandom_range(2) == 0);
                idx_in = 2'($urandom_range(3));
                en     = ($urandom_range(99) < 85);
                if ($urandom_range(19) == 0) dwell = 8'($urandom_range(3));
                if ($urandom_range(19) == 0) last  = 2'($urandom_range(3));
            end
            model_step();
            tick();
            check("rand_o", 32'(o), 32'(model_o()));
            check("rand_idx", 32'(idx), 32'(m_idx));
            check("rand_wrap", 32'(wrap), 32'(m_wrap));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
